// File: rtl/add_serial_nbit_pkg.sv
// Shared definitions for the serial adder: FSM encoding and index sizing.
package add_serial_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the slice index: clog2 of the slice count, never below 1 bit.
  function automatic int idx_w(input int nchunk);
    return (nchunk <= 2) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/fa_nbit.sv
// Combinational n-bit ripple adder used for one slice of the serial adder.
module fa_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] sum;

  // Plain add with one guard bit; the guard bit is the carry out.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    s    = sum[WIDTH-1:0];
    cout = sum[WIDTH];
  end

endmodule

// File: rtl/add_serial_nbit.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, carry kept in a flop.
module add_serial_nbit
  import add_serial_nbit_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_w(NCHUNK);
  localparam int MSB    = WIDTH - 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("add_serial_nbit: WIDTH must be a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, bx_q, bx_d, res_q, res_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

  logic [CHUNK-1:0]  sl_a, sl_b, sl_s;
  logic              sl_co, last;
  logic [WIDTH-1:0]  res_nxt;

  fa_nbit #(.WIDTH(CHUNK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_co)
  );

  // Select the current slice and merge its sum into the running result.
  always_comb begin
    sl_a    = a_q[int'(idx_q)*CHUNK +: CHUNK];
    sl_b    = bx_q[int'(idx_q)*CHUNK +: CHUNK];
    last    = (idx_q == IDXW'(NCHUNK - 1));
    res_nxt = res_q;
    res_nxt[int'(idx_q)*CHUNK +: CHUNK] = sl_s;
  end

  // Next-state: accept in IDLE/DONE, one slice per RUN cycle, publish on the last.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    bx_d    = bx_q;
    res_d   = res_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          // Subtract is a + ~b + 1; the borrow-in flips that +1 off.
          a_d     = a;
          bx_d    = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        carry_d = sl_co;
        res_d   = res_nxt;
        idx_d   = idx_q + IDXW'(1);
        if (last) begin
          // Index parks at 0 so the slice select never leaves the operand.
          idx_d   = '0;
          state_d = ST_DONE;
          s_d     = res_nxt;
          cout_d  = sl_co;
          ovf_d   = (a_q[MSB] == bx_q[MSB]) && (res_nxt[MSB] != a_q[MSB]);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // All state and registered outputs; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_serial_nbit.sv
// Scoreboard bench: three instances (CHUNK=2,10,5) against an arithmetic model.
module tb_add_serial_nbit;

  typedef struct {
    logic [9:0] s;
    logic       co;
    logic       ov;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [9:0] ta = '0, tb = '0;
  logic       tcin = 1'b0, tsub = 1'b0;
  logic [2:0] busy_v, done_v, cout_v, ovf_v;
  logic [9:0] s_v [3];

  int   cyc = 0;
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$], q1[$], q2[$];
  logic [9:0] last_s [3];
  logic       last_co [3], last_ov [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 2 : ((g == 1) ? 10 : 5);
    add_serial_nbit #(.WIDTH(10), .CHUNK(CH)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .a     (ta),
      .b     (tb),
      .cin   (tcin),
      .sub   (tsub),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .s     (s_v[g]),
      .cout  (cout_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  function automatic int nch(input int d);
    return (d == 0) ? 5 : ((d == 1) ? 1 : 2);
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(input int d);
    case (d)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qpush(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [9:0] ia, input logic [9:0] ib,
                                 input logic ic, input logic is);
    exp_t e;
    int ua, ub, sa, sb, ci, r, sr;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    ci = ic ? 1 : 0;
    if (is) begin
      r    = ua - ub - ci;
      sr   = sa - sb - ci;
      e.co = (r >= 0);
    end else begin
      r    = ua + ub + ci;
      sr   = sa + sb + ci;
      e.co = (r > 1023);
    end
    e.s   = r[9:0];
    e.ov  = (sr > 511) || (sr < -512);
    e.due = 0;
    return e;
  endfunction

  // Monitor: compares each done against the queue head; otherwise checks busy and held outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        exp_t e;
        logic eb;
        checks++;
        if (done_v[d]) begin
          if (qsize(d) == 0) begin
            failures++;
            $display("FAIL dut%0d unexpected_done cyc=%0d s=%0d (no operation outstanding)", d, cyc, s_v[d]);
          end else begin
            e = qfront(d);
            qpop(d);
            if (s_v[d] !== e.s || cout_v[d] !== e.co || ovf_v[d] !== e.ov || busy_v[d] !== 1'b0 || cyc != e.due) begin
              failures++;
              $display("FAIL dut%0d result got s=%0d cout=%b ovf=%b busy=%b cyc=%0d want s=%0d cout=%b ovf=%b busy=0 cyc=%0d",
                       d, s_v[d], cout_v[d], ovf_v[d], busy_v[d], cyc, e.s, e.co, e.ov, e.due);
            end
            last_s[d] = e.s; last_co[d] = e.co; last_ov[d] = e.ov;
          end
        end else begin
          eb = 1'b0;
          if (qsize(d) != 0) begin
            e = qfront(d);
            if (cyc >= e.due) begin
              failures++;
              $display("FAIL dut%0d missing_done cyc=%0d due=%0d", d, cyc, e.due);
              qpop(d);
            end else eb = 1'b1;
          end
          if (busy_v[d] !== eb || s_v[d] !== last_s[d] || cout_v[d] !== last_co[d] || ovf_v[d] !== last_ov[d]) begin
            failures++;
            $display("FAIL dut%0d hold cyc=%0d got busy=%b s=%0d cout=%b ovf=%b want busy=%b s=%0d cout=%b ovf=%b",
                     d, cyc, busy_v[d], s_v[d], cout_v[d], ovf_v[d], eb, last_s[d], last_co[d], last_ov[d]);
          end
        end
      end
    end
  end

  // Issue one op; called #1 after a posedge. Returns #1 after the edge that completes it,
  // i.e. in the DONE cycle, so an immediate next call is back-to-back.
  task automatic issue(input int d, input logic [9:0] ia, input logic [9:0] ib,
                       input logic ic, input logic is, input int gap, input bit noise);
    exp_t e;
    repeat (gap) begin @(posedge clk); #1; end
    ta = ia; tb = ib; tcin = ic; tsub = is;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    e = model(ia, ib, ic, is);
    e.due = cyc + nch(d);
    qpush(d, e);
    for (int i = 0; i < nch(d); i++) begin
      ta = 10'($urandom); tb = 10'($urandom);
      tcin = 1'($urandom); tsub = 1'($urandom);
      if (noise && $urandom_range(0, 1) == 1) start_v[d] = 1'b1;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
    end
  endtask

  task automatic clear_expect();
    q0.delete(); q1.delete(); q2.delete();
    for (int d = 0; d < 3; d++) begin
      last_s[d] = '0; last_co[d] = 1'b0; last_ov[d] = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    clear_expect();
    // Reset held two edges with start high on every instance.
    rst = 1'b1;
    start_v = 3'b111;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases on the CHUNK=2 instance; first two are back-to-back.
    issue(0, 10'd1000, 10'd100, 1'b1, 1'b0, 0, 1'b0);
    issue(0, 10'd5,    10'd7,   1'b0, 1'b1, 0, 1'b1);
    issue(0, 10'd7,    10'd5,   1'b1, 1'b1, 2, 1'b1);
    issue(0, 10'd511,  10'd1,   1'b0, 1'b0, 1, 1'b0);
    issue(0, 10'd512,  10'd1,   1'b0, 1'b1, 0, 1'b1);

    // Reset during the third RUN cycle: no done, outputs cleared.
    @(posedge clk); #1;
    ta = 10'd300; tb = 10'd200; tcin = 1'b0; tsub = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    e = model(10'd300, 10'd200, 1'b0, 1'b0);
    e.due = cyc + nch(0);
    q0.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_expect();
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Random regression on each instance.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 200; n++) begin
        issue(d, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)),
              1'($urandom));
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (qsize(d) != 0) begin
        failures++;
        $display("FAIL dut%0d drain outstanding=%0d want 0", d, qsize(d));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
